// File: rtl/exu_bru_ctrl.sv
// Branch/jump resolution unit: compares operands, checks the front-end prediction and
// issues a registered redirect to the IFU. Also handles FENCE drain waits and interrupt preemption.
module exu_bru_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned IALIGN_LSB    = 2,
    parameter int unsigned FENCE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        bjp_op_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [ADDR_W-1:0] jump_op1_i,
    input  logic [ADDR_W-1:0] jump_op2_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              pred_taken_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    input  logic              drain_idle_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    output logic              redirect_valid_o,
    input  logic              redirect_ready_i,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              resolve_valid_o,
    output logic              resolve_taken_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o,
    output logic              fence_timeout_o
);

    localparam int unsigned CNT_W = (FENCE_TIMEOUT > 1) ? $clog2(FENCE_TIMEOUT) : 1;

    localparam logic [3:0] OP_JAL   = 4'd1;
    localparam logic [3:0] OP_JALR  = 4'd2;
    localparam logic [3:0] OP_BEQ   = 4'd3;
    localparam logic [3:0] OP_BNE   = 4'd4;
    localparam logic [3:0] OP_BLT   = 4'd5;
    localparam logic [3:0] OP_BGE   = 4'd6;
    localparam logic [3:0] OP_BLTU  = 4'd7;
    localparam logic [3:0] OP_BGEU  = 4'd8;
    localparam logic [3:0] OP_FENCE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FENCE_WAIT,
        ST_HOLD
    } state_e;

    state_e              r_state, w_state_n;
    logic                r_redirect_valid, w_redirect_valid_n;
    logic [ADDR_W-1:0]   r_redirect_addr, w_redirect_addr_n;
    logic                r_resolve_valid, w_resolve_valid_n;
    logic                r_resolve_taken, w_resolve_taken_n;
    logic                r_misalign, w_misalign_n;
    logic [ADDR_W-1:0]   r_misalign_addr, w_misalign_addr_n;
    logic                r_fence_timeout, w_fence_timeout_n;
    logic [CNT_W-1:0]    r_fence_cnt, w_fence_cnt_n;
    logic [ADDR_W-1:0]   r_fence_target, w_fence_target_n;

    logic                w_accept;
    logic                w_eq, w_slt, w_ult;
    logic [ADDR_W-1:0]   w_sum, w_target, w_fallthrough;
    logic                w_taken, w_is_bj, w_misaligned, w_mispredict;

    assign req_ready_o = (r_state == ST_IDLE) & ~int_assert_i;
    assign w_accept    = req_valid_i & req_ready_o;

    assign w_eq          = (op1_i == op2_i);
    assign w_slt         = ($signed(op1_i) < $signed(op2_i));
    assign w_ult         = (op1_i < op2_i);
    assign w_sum         = jump_op1_i + jump_op2_i;
    assign w_target      = (bjp_op_i == OP_JALR) ? {w_sum[ADDR_W-1:1], 1'b0} : w_sum;
    assign w_fallthrough = inst_addr_i + ADDR_W'(4);
    assign w_is_bj       = (bjp_op_i >= OP_JAL) && (bjp_op_i <= OP_BGEU);
    assign w_misaligned  = |w_target[IALIGN_LSB-1:0];
    assign w_mispredict  = (w_taken != pred_taken_i) | (w_taken & (w_target != pred_target_i));

    // Actual branch direction
    always_comb begin
        w_taken = 1'b0;
        case (bjp_op_i)
            OP_JAL, OP_JALR: w_taken = 1'b1;
            OP_BEQ:          w_taken = w_eq;
            OP_BNE:          w_taken = ~w_eq;
            OP_BLT:          w_taken = w_slt;
            OP_BGE:          w_taken = ~w_slt;
            OP_BLTU:         w_taken = w_ult;
            OP_BGEU:         w_taken = ~w_ult;
            default:         w_taken = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_n          = r_state;
        w_redirect_valid_n = r_redirect_valid;
        w_redirect_addr_n  = r_redirect_addr;
        w_resolve_valid_n  = 1'b0;
        w_resolve_taken_n  = 1'b0;
        w_misalign_n       = 1'b0;
        w_misalign_addr_n  = r_misalign_addr;
        w_fence_timeout_n  = 1'b0;
        w_fence_cnt_n      = r_fence_cnt;
        w_fence_target_n   = r_fence_target;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_bj) begin
                    w_resolve_valid_n = 1'b1;
                    w_resolve_taken_n = w_taken;
                    if (w_taken && w_misaligned) begin
                        w_misalign_n      = 1'b1;
                        w_misalign_addr_n = w_target;
                    end else if (w_mispredict) begin
                        w_redirect_valid_n = 1'b1;
                        w_redirect_addr_n  = w_taken ? w_target : w_fallthrough;
                        w_state_n          = ST_HOLD;
                    end
                end else if (w_accept && (bjp_op_i == OP_FENCE)) begin
                    w_fence_target_n = w_target;
                    w_fence_cnt_n    = '0;
                    w_state_n        = ST_FENCE_WAIT;
                end
            end
            ST_FENCE_WAIT: begin
                w_fence_cnt_n = r_fence_cnt + CNT_W'(1);
                if (drain_idle_i || (r_fence_cnt == CNT_W'(FENCE_TIMEOUT - 1))) begin
                    w_redirect_valid_n = 1'b1;
                    w_redirect_addr_n  = r_fence_target;
                    w_fence_timeout_n  = ~drain_idle_i;
                    w_state_n          = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_ready_i) begin
                    w_redirect_valid_n = 1'b0;
                    w_state_n          = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // Interrupt overrides whatever the state machine decided, including a fence in flight
        if (int_assert_i) begin
            w_redirect_valid_n = 1'b1;
            w_redirect_addr_n  = int_addr_i;
            w_fence_timeout_n  = 1'b0;
            w_state_n          = ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= '0;
            r_resolve_valid  <= 1'b0;
            r_resolve_taken  <= 1'b0;
            r_misalign       <= 1'b0;
            r_misalign_addr  <= '0;
            r_fence_timeout  <= 1'b0;
            r_fence_cnt      <= '0;
            r_fence_target   <= '0;
        end else begin
            r_state          <= w_state_n;
            r_redirect_valid <= w_redirect_valid_n;
            r_redirect_addr  <= w_redirect_addr_n;
            r_resolve_valid  <= w_resolve_valid_n;
            r_resolve_taken  <= w_resolve_taken_n;
            r_misalign       <= w_misalign_n;
            r_misalign_addr  <= w_misalign_addr_n;
            r_fence_timeout  <= w_fence_timeout_n;
            r_fence_cnt      <= w_fence_cnt_n;
            r_fence_target   <= w_fence_target_n;
        end
    end

    assign redirect_valid_o = r_redirect_valid;
    assign redirect_addr_o  = r_redirect_addr;
    assign resolve_valid_o  = r_resolve_valid;
    assign resolve_taken_o  = r_resolve_taken;
    assign misalign_o       = r_misalign;
    assign misalign_addr_o  = r_misalign_addr;
    assign fence_timeout_o  = r_fence_timeout;

endmodule

// File: tb/tb_exu_bru_ctrl.sv
// Bench for exu_bru_ctrl: directed scenarios plus randomized single-request transactions
// checked against expectations computed from the branch rules.
module tb_exu_bru_ctrl;

    logic        clk, rst;
    logic        req_valid, pred_taken, drain_idle, int_assert, redirect_ready;
    logic [3:0]  bjp_op;
    logic [31:0] op1, op2, jop1, jop2, inst_addr, pred_target, int_addr;

    logic        req_ready, rv, res_v, res_t, mis, fto;
    logic [31:0] raddr, mis_addr;
    logic        c_req_ready, c_rv, c_res_v, c_res_t, c_mis, c_fto;
    logic [31:0] c_raddr, c_mis_addr;

    int n_tests = 0;
    int n_fail  = 0;

    exu_bru_ctrl #(.XLEN(32), .ADDR_W(32), .IALIGN_LSB(2), .FENCE_TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .bjp_op_i(bjp_op), .op1_i(op1), .op2_i(op2), .jump_op1_i(jop1), .jump_op2_i(jop2),
        .inst_addr_i(inst_addr), .pred_taken_i(pred_taken), .pred_target_i(pred_target),
        .drain_idle_i(drain_idle), .int_assert_i(int_assert), .int_addr_i(int_addr),
        .redirect_valid_o(rv), .redirect_ready_i(redirect_ready), .redirect_addr_o(raddr),
        .resolve_valid_o(res_v), .resolve_taken_o(res_t), .misalign_o(mis),
        .misalign_addr_o(mis_addr), .fence_timeout_o(fto));

    exu_bru_ctrl #(.XLEN(32), .ADDR_W(32), .IALIGN_LSB(1), .FENCE_TIMEOUT(8)) u_dut_c (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(c_req_ready),
        .bjp_op_i(bjp_op), .op1_i(op1), .op2_i(op2), .jump_op1_i(jop1), .jump_op2_i(jop2),
        .inst_addr_i(inst_addr), .pred_taken_i(pred_taken), .pred_target_i(pred_target),
        .drain_idle_i(drain_idle), .int_assert_i(int_assert), .int_addr_i(int_addr),
        .redirect_valid_o(c_rv), .redirect_ready_i(redirect_ready), .redirect_addr_o(c_raddr),
        .resolve_valid_o(c_res_v), .resolve_taken_o(c_res_t), .misalign_o(c_mis),
        .misalign_addr_o(c_mis_addr), .fence_timeout_o(c_fto));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] j1, input logic [31:0] j2, input logic [31:0] pc,
                         input logic pt, input logic [31:0] ptg);
        req_valid = 1'b1; bjp_op = op; op1 = a; op2 = b; jop1 = j1; jop2 = j2;
        inst_addr = pc; pred_taken = pt; pred_target = ptg;
        step();
        req_valid = 1'b0; bjp_op = 4'd0;
    endtask

    // Hold a pending redirect for a random number of cycles, then hand it off
    task automatic finish_redirect(input string tag, input logic [31:0] exp_addr);
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) begin
            step();
            chk({tag, "_hold_valid"}, 64'(rv), 64'(1));
            chk({tag, "_hold_addr"}, 64'(raddr), 64'(exp_addr));
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk({tag, "_done_valid"}, 64'(rv), 64'(0));
        chk({tag, "_done_ready"}, 64'(req_ready), 64'(1));
    endtask

    function automatic logic m_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1, 4'd2: return 1'b1;
            4'd3: return a == b;
            4'd4: return a != b;
            4'd5: return $signed(a) < $signed(b);
            4'd6: return !($signed(a) < $signed(b));
            4'd7: return a < b;
            4'd8: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [3:0] op, input logic [31:0] j1, input logic [31:0] j2);
        logic [31:0] t;
        t = j1 + j2;
        if (op == 4'd2) t = t & ~32'h1;
        return t;
    endfunction

    initial begin
        logic [3:0]  r_op;
        logic [31:0] a, b, j1, j2, pc, t, ptg, exp_addr;
        logic        pt, tk, is_bj, e_mis, e_redir;

        rst = 1'b1; req_valid = 1'b0; bjp_op = 4'd0; op1 = '0; op2 = '0; jop1 = '0; jop2 = '0;
        inst_addr = '0; pred_taken = 1'b0; pred_target = '0; drain_idle = 1'b0;
        int_assert = 1'b0; int_addr = '0; redirect_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_rv", 64'(rv), 64'(0));
        chk("rst_addr", 64'(raddr), 64'(0));
        chk("rst_resv", 64'(res_v), 64'(0));
        chk("rst_rest", 64'(res_t), 64'(0));
        chk("rst_mis", 64'(mis), 64'(0));
        chk("rst_misaddr", 64'(mis_addr), 64'(0));
        chk("rst_fto", 64'(fto), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(1));

        // BEQ taken, predicted not taken
        issue(4'd3, 32'd5, 32'd5, 32'h100, 32'h20, 32'h40, 1'b0, 32'h0);
        chk("beq_resv", 64'(res_v), 64'(1));
        chk("beq_rest", 64'(res_t), 64'(1));
        chk("beq_rv", 64'(rv), 64'(1));
        chk("beq_addr", 64'(raddr), 64'h120);
        chk("beq_ready_hold", 64'(req_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("beq_hold_rv", 64'(rv), 64'(1));
            chk("beq_hold_addr", 64'(raddr), 64'h120);
            chk("beq_pulse_once", 64'(res_v), 64'(0));
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("beq_hs_rv", 64'(rv), 64'(0));
        chk("beq_hs_ready", 64'(req_ready), 64'(1));

        // BLT signed taken, correctly predicted; BLTU not taken, mispredicted
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h100, 32'h80, 1'b1, 32'h200);
        chk("blt_resv", 64'(res_v), 64'(1));
        chk("blt_rest", 64'(res_t), 64'(1));
        chk("blt_rv", 64'(rv), 64'(0));
        step();
        chk("blt_pulse_end", 64'(res_v), 64'(0));
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h100, 32'h80, 1'b1, 32'h200);
        chk("bltu_resv", 64'(res_v), 64'(1));
        chk("bltu_rest", 64'(res_t), 64'(0));
        chk("bltu_rv", 64'(rv), 64'(1));
        chk("bltu_addr", 64'(raddr), 64'h84);
        finish_redirect("bltu", 32'h84);

        // JALR misaligned under 4-byte alignment, fine under 2-byte alignment
        issue(4'd2, 32'd0, 32'd0, 32'h1003, 32'h0, 32'h90, 1'b0, 32'h0);
        chk("jalr_mis", 64'(mis), 64'(1));
        chk("jalr_misaddr", 64'(mis_addr), 64'h1002);
        chk("jalr_rv", 64'(rv), 64'(0));
        chk("jalr_resv", 64'(res_v), 64'(1));
        chk("jalr_ready", 64'(req_ready), 64'(1));
        chk("jalr_c_mis", 64'(c_mis), 64'(0));
        chk("jalr_c_rv", 64'(c_rv), 64'(1));
        chk("jalr_c_addr", 64'(c_raddr), 64'h1002);
        step();
        chk("jalr_mis_pulse", 64'(mis), 64'(0));
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk("jalr_c_done", 64'(c_rv), 64'(0));

        // FENCE released by drain
        issue(4'd9, 32'd0, 32'd0, 32'h400, 32'h0, 32'hA0, 1'b0, 32'h0);
        chk("fence_resv", 64'(res_v), 64'(0));
        chk("fence_ready", 64'(req_ready), 64'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fence_wait_rv", 64'(rv), 64'(0));
        end
        drain_idle = 1'b1;
        step();
        drain_idle = 1'b0;
        chk("fence_drain_rv", 64'(rv), 64'(1));
        chk("fence_drain_addr", 64'(raddr), 64'h400);
        chk("fence_drain_fto", 64'(fto), 64'(0));
        finish_redirect("fence", 32'h400);

        // FENCE forced by timeout after 8 wait cycles
        issue(4'd9, 32'd0, 32'd0, 32'h3F0, 32'h10, 32'hA0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("fto_wait_rv", 64'(rv), 64'(0));
            chk("fto_wait_fto", 64'(fto), 64'(0));
        end
        step();
        chk("fto_rv", 64'(rv), 64'(1));
        chk("fto_addr", 64'(raddr), 64'h400);
        chk("fto_pulse", 64'(fto), 64'(1));
        step();
        chk("fto_pulse_end", 64'(fto), 64'(0));
        finish_redirect("fto", 32'h400);

        // Interrupt preempts a held redirect
        issue(4'd3, 32'd5, 32'd5, 32'h100, 32'h20, 32'h40, 1'b0, 32'h0);
        int_assert = 1'b1; int_addr = 32'h8;
        #1;
        chk("int_ready", 64'(req_ready), 64'(0));
        step();
        int_assert = 1'b0;
        chk("int_hold_rv", 64'(rv), 64'(1));
        chk("int_hold_addr", 64'(raddr), 64'h8);
        finish_redirect("int_hold", 32'h8);

        // Interrupt discards a fence in flight
        issue(4'd9, 32'd0, 32'd0, 32'h400, 32'h0, 32'hA0, 1'b0, 32'h0);
        step();
        int_assert = 1'b1;
        step();
        int_assert = 1'b0;
        chk("int_fence_addr", 64'(raddr), 64'h8);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("int_fence_fto", 64'(fto), 64'(0));
            chk("int_fence_keep", 64'(raddr), 64'h8);
        end
        finish_redirect("int_fence", 32'h8);

        // Request blocked by interrupt; vector reloads while held
        int_assert = 1'b1;
        req_valid = 1'b1; bjp_op = 4'd3; op1 = 32'd5; op2 = 32'd5; jop1 = 32'h100; jop2 = 32'h20;
        pred_taken = 1'b0;
        #1;
        chk("int_req_ready", 64'(req_ready), 64'(0));
        step();
        chk("int_req_addr", 64'(raddr), 64'h8);
        chk("int_req_resv", 64'(res_v), 64'(0));
        int_addr = 32'h10;
        step();
        req_valid = 1'b0; bjp_op = 4'd0; int_assert = 1'b0;
        chk("int_reload", 64'(raddr), 64'h10);
        finish_redirect("int_reload", 32'h10);

        // Reset while holding a redirect
        issue(4'd3, 32'd5, 32'd5, 32'h100, 32'h20, 32'h40, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_rv", 64'(rv), 64'(0));
        chk("midrst_addr", 64'(raddr), 64'(0));
        chk("midrst_ready", 64'(req_ready), 64'(1));

        // Target wraps modulo 2^32
        issue(4'd1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 32'h50, 1'b0, 32'h0);
        chk("wrap_rv", 64'(rv), 64'(1));
        chk("wrap_addr", 64'(raddr), 64'h4);
        finish_redirect("wrap", 32'h4);

        // Randomized single-request transactions
        for (int it = 0; it < 200; it++) begin
            r_op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            j1 = $urandom; j2 = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                j1 = j1 & ~32'h3; j2 = j2 & ~32'h3;
            end
            pc = $urandom & ~32'h3;
            t = m_target(r_op, j1, j2);
            tk = m_taken(r_op, a, b);
            pt = 1'($urandom_range(0, 1));
            ptg = ($urandom_range(0, 1) == 1) ? t : $urandom;
            is_bj = (r_op >= 4'd1) && (r_op <= 4'd8);
            e_mis = is_bj && tk && (t[1:0] != 2'b00);
            e_redir = is_bj && !e_mis && ((tk != pt) || (tk && (t != ptg)));
            exp_addr = tk ? t : pc + 32'd4;
            drain_idle = (r_op == 4'd9);
            issue(r_op, a, b, j1, j2, pc, pt, ptg);
            chk("rnd_resv", 64'(res_v), 64'(is_bj));
            if (is_bj) chk("rnd_rest", 64'(res_t), 64'(tk));
            chk("rnd_mis", 64'(mis), 64'(e_mis));
            if (e_mis) chk("rnd_misaddr", 64'(mis_addr), 64'(t));
            chk("rnd_rv", 64'(rv), 64'(e_redir));
            if (e_redir) begin
                chk("rnd_addr", 64'(raddr), 64'(exp_addr));
                finish_redirect("rnd", exp_addr);
            end else if (r_op == 4'd9) begin
                step();
                drain_idle = 1'b0;
                chk("rnd_fence_rv", 64'(rv), 64'(1));
                chk("rnd_fence_addr", 64'(raddr), 64'(t));
                finish_redirect("rnd_fence", t);
            end else begin
                step();
                chk("rnd_idle_resv", 64'(res_v), 64'(0));
                chk("rnd_idle_ready", 64'(req_ready), 64'(1));
            end
            drain_idle = 1'b0;
            if (c_rv) begin
                redirect_ready = 1'b1;
                step();
                redirect_ready = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_bru_ctrl.md
Name: exu_bru_ctrl

Overview:
- Sequential branch/jump resolution unit in the EXU, parametrised in data width, address width and instruction alignment.
- Resolves conditional branches, JAL/JALR and FENCE against the front-end prediction.
- Produces a registered redirect to the IFU with a valid/ready handshake, plus a one-cycle resolve pulse for predictor update.
- Adds interrupt preemption, fence drain wait with timeout, and misaligned-target detection.

Parameters:
- XLEN, 32, width of compare operands
- ADDR_W, 32, width of instruction addresses
- IALIGN_LSB, 2, number of target LSBs that must be zero (1 when compressed instructions are enabled)
- FENCE_TIMEOUT, 64, maximum FENCE_WAIT cycles before a forced redirect (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  resolve request valid
- req_ready_o  out  1  unit can accept a request
- bjp_op_i  in  4  operation: 0 none, 1 JAL, 2 JALR, 3 BEQ, 4 BNE, 5 BLT, 6 BGE, 7 BLTU, 8 BGEU, 9 FENCE; 10-15 treated as none
- op1_i  in  XLEN  compare operand 1
- op2_i  in  XLEN  compare operand 2
- jump_op1_i  in  ADDR_W  target addend 1
- jump_op2_i  in  ADDR_W  target addend 2
- inst_addr_i  in  ADDR_W  PC of the instruction
- pred_taken_i  in  1  front-end predicted taken
- pred_target_i  in  ADDR_W  front-end predicted target
- drain_idle_i  in  1  LSU/pipeline drained (used for FENCE)
- int_assert_i  in  1  interrupt redirect request
- int_addr_i  in  ADDR_W  interrupt vector
- redirect_valid_o  out  1  redirect pending
- redirect_ready_i  in  1  IFU accepts redirect
- redirect_addr_o  out  ADDR_W  redirect PC
- resolve_valid_o  out  1  one-cycle pulse: a branch/jump was resolved
- resolve_taken_o  out  1  actual direction, qualified by resolve_valid_o
- misalign_o  out  1  one-cycle pulse: taken target misaligned
- misalign_addr_o  out  ADDR_W  offending target, qualified by misalign_o
- fence_timeout_o  out  1  one-cycle pulse: fence forced by timeout

Behaviour:
- States: IDLE, FENCE_WAIT, HOLD.
- Reset (sync): state IDLE; redirect_valid_o, resolve_valid_o, resolve_taken_o, misalign_o, fence_timeout_o = 0; redirect_addr_o, misalign_addr_o = 0; fence counter = 0.
- req_ready_o = (state==IDLE) & ~int_assert_i. A request is accepted when req_valid_i & req_ready_o.
- Compares:
  - eq = op1==op2
  - signed lt = $signed(op1) < $signed(op2)
  - unsigned lt = op1 < op2
- Target arithmetic:
  - target = jump_op1_i + jump_op2_i, modulo 2^ADDR_W.
  - JALR clears target bit 0.
  - Fallthrough = inst_addr_i + 4, modulo 2^ADDR_W.
- Taken rules: JAL/JALR always taken; BEQ eq; BNE ~eq; BLT slt; BGE ~slt; BLTU ult; BGEU ~ult.
- Accept of branch/JAL/JALR; all results are registered and appear one cycle after accept:
  - resolve_valid_o=1 and resolve_taken_o=taken.
  - If taken and target[IALIGN_LSB-1:0]!=0: misalign_o=1, misalign_addr_o=target, no redirect, stay IDLE.
  - Else mispredict = (taken != pred_taken_i) | (taken & target != pred_target_i).
    - On mispredict: redirect_valid_o=1 with addr = taken ? target : fallthrough; go HOLD.
    - Otherwise stay IDLE.
- Accept of FENCE:
  - Capture target; clear counter; go FENCE_WAIT.
  - No resolve pulse.
- FENCE_WAIT:
  - Counter increments each cycle.
  - If drain_idle_i: load redirect with the captured target and go HOLD.
  - Else if counter reaches FENCE_TIMEOUT-1: same load, fence_timeout_o=1 for one cycle.
- Accept of op none: no outputs; stay IDLE.
- HOLD:
  - redirect_valid_o and redirect_addr_o are held stable until redirect_ready_i.
  - On the handshake cycle, the next cycle has redirect_valid_o=0 and state IDLE.
- Interrupt priority, from any state, when int_assert_i=1:
  - Next cycle: redirect_valid_o=1, redirect_addr_o=int_addr_i, state HOLD.
  - A pending redirect or FENCE_WAIT is discarded.
  - A handshake completing in that same cycle still counts as delivered.
  - No request is accepted in that cycle.
  - If int_assert_i stays high, the address reloads every cycle.
- Pulse outputs (resolve/misalign/fence_timeout) are high for exactly one cycle.
- Reset mid-operation abandons all state, including held redirects, in the same edge.

Test Plan:
1. BEQ, op1=op2=5, pred_taken=0, jump_op1=0x100, jump_op2=0x20 -> next cycle resolve_valid=1, resolve_taken=1, redirect_valid=1, addr=0x120. Hold with ready=0 for 3 cycles, addr stable; ready=1 -> valid=0 next cycle, req_ready=1.
2. BLT, op1=0xFFFFFFFF, op2=1, pred_taken=1, pred_target=0x200, jump sum=0x200 -> taken (signed -1<1), correct prediction, no redirect, resolve pulse only. Repeat as BLTU -> not taken, redirect addr=inst_addr+4 (inst_addr=0x80 -> 0x84).
3. JALR, jump_op1=0x1003, jump_op2=0, IALIGN_LSB=2 -> target 0x1002, misalign_o=1, misalign_addr=0x1002, no redirect. With IALIGN_LSB=1 -> redirect to 0x1002.
4. FENCE, target 0x400, drain_idle=0 for 5 cycles then 1 -> redirect 0x400 appears one cycle after drain_idle rises. With drain_idle stuck 0 and FENCE_TIMEOUT=8 -> fence_timeout_o pulse, redirect 0x400 after 8 wait cycles.
5. Redirect 0x120 pending in HOLD, int_assert=1 with int_addr=0x8 -> next cycle addr=0x8 and valid=1. int_assert during FENCE_WAIT -> fence dropped, redirect 0x8. req_valid with int_assert high -> req_ready=0.
6. rst=1 while in HOLD -> next cycle all outputs 0, state IDLE, req_ready=1. Wrap case: jump_op1=0xFFFFFFFC, jump_op2=8 -> target 0x4.
